// File: rtl/trig_pkg.sv
// Shared encodings for the trigger sequencer: FSM states, source select codes
// and the width of the missed-trigger counter.
package trig_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_FIRE    = 3'd2;
  localparam logic [2:0] ST_HOLDOFF = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [1:0] SRC_CPU   = 2'd0;
  localparam logic [1:0] SRC_EXT   = 2'd1;
  localparam logic [1:0] SRC_TIMER = 2'd2;
  localparam logic [1:0] SRC_ANY   = 2'd3;

  localparam int MISSED_W = 16;
endpackage

// File: rtl/edge_sync.sv
// Optional flip-flop synchronizer chain followed by a rising-edge detector.
// STAGES=0 bypasses the chain for inputs that are already in the clk domain.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic lvl, prev;

  generate
    if (STAGES == 0) begin : g_direct
      assign lvl = d;
    end else begin : g_sync
      logic [STAGES-1:0] chain;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain <= '0;
        end else begin
          chain[0] <= d;
          for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
      end
      assign lvl = chain[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= lvl;
  end

  assign rise = lvl & ~prev;
endmodule

// File: rtl/trig_sequencer.sv
// Trigger sequencer: qualifies CPU / external / timer trigger sources and emits
// a programmed number of single-cycle pulses separated by a holdoff interval.
module trig_sequencer import trig_pkg::*; #(
  parameter int CNT_W       = 32,
  parameter int REP_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                abort,
  input  logic [1:0]          src_sel,
  input  logic                cpu_flag,
  input  logic                ext_trig,
  input  logic [CNT_W-1:0]    period,
  input  logic [CNT_W-1:0]    holdoff,
  input  logic [REP_W-1:0]    num_reps,
  output logic                trig_out,
  output logic                busy,
  output logic                done,
  output logic [REP_W-1:0]    rep_count,
  output logic [MISSED_W-1:0] missed_count
);
  logic [2:0]       state, state_nx;
  logic [1:0]       src_q;
  logic [CNT_W-1:0] period_q, holdoff_q, tmr, ho_cnt, period_m1;
  logic [REP_W-1:0] reps_q;
  logic             cpu_rise, ext_rise, edge_evt, tmr_hit, evt;

  edge_sync #(.STAGES(0)) u_cpu_edge (
    .clk(clk), .rst_n(rst_n), .d(cpu_flag), .rise(cpu_rise)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_ext_edge (
    .clk(clk), .rst_n(rst_n), .d(ext_trig), .rise(ext_rise)
  );

  // Edge-type sources; the timer is handled separately since it only runs in ARMED.
  always_comb begin
    edge_evt = 1'b0;
    case (src_q)
      SRC_CPU: edge_evt = cpu_rise;
      SRC_EXT: edge_evt = ext_rise;
      SRC_ANY: edge_evt = cpu_rise | ext_rise;
      default: edge_evt = 1'b0;
    endcase
  end

  // A zero period behaves like one so the timer source can never stall.
  assign period_m1 = (period_q == '0) ? '0 : period_q - CNT_W'(1);
  assign tmr_hit   = (src_q == SRC_TIMER) && (tmr == period_m1);
  assign evt       = edge_evt | tmr_hit;

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (arm) state_nx = ST_ARMED;
        ST_ARMED:   if (evt) state_nx = ST_FIRE;
        ST_FIRE: begin
          if (reps_q != '0 && rep_count == reps_q) state_nx = ST_DONE;
          else if (holdoff_q == '0)                state_nx = ST_ARMED;
          else                                     state_nx = ST_HOLDOFF;
        end
        ST_HOLDOFF: if (ho_cnt == holdoff_q - CNT_W'(1)) state_nx = ST_ARMED;
        ST_DONE:    state_nx = ST_IDLE;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      trig_out     <= 1'b0;
      done         <= 1'b0;
      tmr          <= '0;
      ho_cnt       <= '0;
      src_q        <= '0;
      period_q     <= '0;
      holdoff_q    <= '0;
      reps_q       <= '0;
      rep_count    <= '0;
      missed_count <= '0;
    end else begin
      state    <= state_nx;
      trig_out <= (state_nx == ST_FIRE);
      done     <= (state_nx == ST_DONE);
      // Timer restarts from zero on every entry into ARMED.
      tmr      <= (state == ST_ARMED && state_nx == ST_ARMED) ? tmr + CNT_W'(1) : '0;
      ho_cnt   <= (state == ST_HOLDOFF) ? ho_cnt + CNT_W'(1) : '0;

      if (state == ST_IDLE && arm && !abort) begin
        src_q        <= src_sel;
        period_q     <= period;
        holdoff_q    <= holdoff;
        reps_q       <= num_reps;
        rep_count    <= '0;
        missed_count <= '0;
      end

      if (state == ST_ARMED && state_nx == ST_FIRE) rep_count <= rep_count + REP_W'(1);

      if (!abort && (state == ST_FIRE || state == ST_HOLDOFF) && edge_evt &&
          missed_count != '1)
        missed_count <= missed_count + MISSED_W'(1);
    end
  end

  assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_trig_sequencer.sv
// Scoreboard bench for trig_sequencer: stimulus queues expected trig/done events,
// a negedge monitor pops and checks them whenever the DUT pulses an output.
module tb_trig_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0, abort = 1'b0, cpu_flag = 1'b0, ext_trig = 1'b0;
  logic [1:0]  src_sel = 2'd0;
  logic [31:0] period = '0, holdoff = '0;
  logic [15:0] num_reps = '0;
  logic        trig_out, busy, done;
  logic [15:0] rep_count, missed_count;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [15:0] rep;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;

  trig_sequencer #(.CNT_W(32), .REP_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .src_sel(src_sel),
    .cpu_flag(cpu_flag), .ext_trig(ext_trig), .period(period), .holdoff(holdoff),
    .num_reps(num_reps), .trig_out(trig_out), .busy(busy), .done(done),
    .rep_count(rep_count), .missed_count(missed_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: consumes expected events as the DUT produces pulses.
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_%s: nothing seen by cycle %0d, required at cycle %0d rep %0d",
               e.is_done ? "done" : "trig", cyc, e.cyc, e.rep);
    end
    if (trig_out || done) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: trig_out=%b done=%b rep=%0d at cycle %0d, required none",
                 trig_out, done, rep_count, cyc);
      end else begin
        e = q.pop_front();
        if (e.is_done != done || e.cyc != cyc || e.rep != rep_count) begin
          n_bad++;
          $display("FAIL %s_event: got done=%b cycle %0d rep %0d, required done=%b cycle %0d rep %0d",
                   e.is_done ? "done" : "trig", done, cyc, rep_count, e.is_done, e.cyc, e.rep);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_done, input int c, input logic [15:0] rep);
    exp_t x;
    x.is_done = is_done; x.cyc = c; x.rep = rep;
    q.push_back(x);
  endtask

  task automatic cfg(input logic [1:0] s, input logic [31:0] p, input logic [31:0] h,
                     input logic [15:0] r);
    src_sel = s; period = p; holdoff = h; num_reps = r;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    // Reset state
    step(2);
    chk("reset_trig", trig_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rep", rep_count, 0);
    chk("reset_missed", missed_count, 0);
    rst_n = 1'b1;
    step(2);
    chk("idle_busy", busy, 0);

    // 1: CPU source, 3 reps, no holdoff
    cfg(2'd0, 32'd0, 32'd0, 16'd3);
    pulse_arm();
    chk("t1_busy_armed", busy, 1);
    for (int k = 1; k <= 3; k++) begin
      step(10);
      cpu_flag = 1'b1;
      push(0, cyc + 1, 16'(k));
      if (k == 3) push(1, cyc + 2, 16'd3);
      step(3);
      cpu_flag = 1'b0;
    end
    step(3);
    chk("t1_busy_end", busy, 0);
    chk("t1_rep", rep_count, 3);

    // 2: TIMER period 5, holdoff 4, 4 reps; config changes after arm are ignored
    cfg(2'd2, 32'd5, 32'd4, 16'd4);
    pulse_arm();
    e0 = cyc;
    cfg(2'd0, 32'd1, 32'd0, 16'd1);
    for (int k = 0; k < 4; k++) push(0, e0 + 5 + 10 * k, 16'(k + 1));
    push(1, e0 + 36, 16'd4);
    step(45);
    chk("t2_busy_end", busy, 0);
    chk("t2_rep", rep_count, 4);

    // 3: EXT source through a 2-stage synchronizer; long level gives one pulse
    cfg(2'd1, 32'd0, 32'd0, 16'd2);
    pulse_arm();
    step(3);
    ext_trig = 1'b1;
    push(0, cyc + 3, 16'd1);
    step(40);
    ext_trig = 1'b0;
    step(5);
    chk("t3_rep", rep_count, 1);
    chk("t3_busy_armed", busy, 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t3_busy_abort", busy, 0);

    // 4: CPU source, holdoff 20; edge during holdoff is counted as missed
    cfg(2'd0, 32'd0, 32'd20, 16'd2);
    pulse_arm();
    step(2);
    cpu_flag = 1'b1;
    push(0, cyc + 1, 16'd1);
    step(2);
    cpu_flag = 1'b0;
    step(3);
    cpu_flag = 1'b1;
    step(2);
    cpu_flag = 1'b0;
    step(1);
    chk("t4_missed_mid", missed_count, 1);
    chk("t4_rep_mid", rep_count, 1);
    step(24);
    cpu_flag = 1'b1;
    push(0, cyc + 1, 16'd2);
    push(1, cyc + 2, 16'd2);
    step(3);
    cpu_flag = 1'b0;
    step(4);
    chk("t4_missed", missed_count, 1);
    chk("t4_rep", rep_count, 2);
    chk("t4_busy_end", busy, 0);

    // 5: TIMER period 3, endless; abort lands on a timer event cycle
    cfg(2'd2, 32'd3, 32'd0, 16'd0);
    pulse_arm();
    e0 = cyc;
    for (int k = 0; k < 12; k++) push(0, e0 + 3 + 4 * k, 16'(k + 1));
    step(50);
    chk("t5_busy_run", busy, 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t5_busy_abort", busy, 0);
    chk("t5_rep_hold", rep_count, 12);
    step(5);
    arm = 1'b1;
    abort = 1'b1;
    step(1);
    arm = 1'b0;
    abort = 1'b0;
    chk("t5_arm_abort_busy", busy, 0);
    chk("t5_arm_abort_rep", rep_count, 12);
    step(5);
    chk("t5_idle_busy", busy, 0);

    // 6: async reset mid-holdoff; a level already high at release must not fire
    cfg(2'd0, 32'd0, 32'd20, 16'd0);
    pulse_arm();
    step(2);
    cpu_flag = 1'b1;
    push(0, cyc + 1, 16'd1);
    step(4);
    chk("t6_busy_holdoff", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rep", rep_count, 0);
    chk("t6_rst_trig", trig_out, 0);
    chk("t6_rst_missed", missed_count, 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    cfg(2'd0, 32'd0, 32'd0, 16'd1);
    pulse_arm();
    step(10);
    chk("t6_no_fire_busy", busy, 1);
    chk("t6_no_fire_rep", rep_count, 0);
    cpu_flag = 1'b0;
    step(2);
    cpu_flag = 1'b1;
    push(0, cyc + 1, 16'd1);
    push(1, cyc + 2, 16'd1);
    step(5);
    cpu_flag = 1'b0;
    chk("t6_busy_end", busy, 0);
    chk("t6_rep", rep_count, 1);

    step(3);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
